mips_multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS CPU.
- Sequences one instruction at a time through fetch, decode, execute, memory and write-back.
- Drives every datapath select and write strobe: PC/IR/register-file/memory enables, ALU operand and op selects, PC source, and RegDst for the 5-bit write-register select mux.
- Sits between the instruction register's opcode field and the datapath; the only external handshake is a memory-ready signal.

---
 rtl/mips_ctrl_pkg.sv | 63 ++++++
 rtl/mips_ctrl_outdec.sv | 95 +++++++++
 rtl/mips_multicycle_ctrl.sv | 88 ++++++++
 tb/tb_mips_multicycle_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// datapath select codes and the bundled control-word struct.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational control-word decode from the current state; FETCH and MEMWR
// strobes qualify on mem_ready, and reset suppresses every strobe.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_e      state_i,
    input  logic        mem_ready_i,
    input  logic        rst_i,
    input  logic [5:0]  opcode_i,
    output ctrl_t       ctrl_o
);

    ctrl_t c;

    always_comb begin
        c = '0;
        unique case (state_i)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_source = PCSRC_ALU;
                c.ir_write  = mem_ready_i;
                c.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                c.alu_src_b  = SRCB_IMMSH2;
                c.alu_op     = ALU_ADD;
                c.illegal_op = !op_legal(opcode_i);
            end
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write  = 1'b1;
                c.i_or_d     = 1'b1;
                c.instr_done = mem_ready_i;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_B;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
                c.instr_done    = 1'b1;
            end
            S_JUMP: begin
                c.pc_write   = 1'b1;
                c.pc_source  = PCSRC_JUMP;
                c.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase

        // Selects may still follow the state; only side-effecting strobes matter in reset.
        if (rst_i) begin
            c.pc_write      = 1'b0;
            c.pc_write_cond = 1'b0;
            c.ir_write      = 1'b0;
            c.reg_write     = 1'b0;
            c.mem_write     = 1'b0;
            c.mem_read      = 1'b0;
            c.instr_done    = 1'b0;
            c.illegal_op    = 1'b0;
        end
    end

    assign ctrl_o = c;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register and next-state dispatch; the
// per-state control word comes from mips_ctrl_outdec.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic       instr_done_o,
    output logic       illegal_op_o
);

    state_e state_q, state_d;
    ctrl_t  ctrl;
    logic   zero_unused;

    // The zero flag gates the PC write in the datapath, not the FSM.
    assign zero_unused = zero_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready_i) state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready_i),
        .rst_i       (rst_i),
        .opcode_i    (opcode_i),
        .ctrl_o      (ctrl)
    );

    assign pc_write_o      = ctrl.pc_write;
    assign pc_write_cond_o = ctrl.pc_write_cond;
    assign i_or_d_o        = ctrl.i_or_d;
    assign mem_read_o      = ctrl.mem_read;
    assign mem_write_o     = ctrl.mem_write;
    assign ir_write_o      = ctrl.ir_write;
    assign mem_to_reg_o    = ctrl.mem_to_reg;
    assign reg_dst_o       = ctrl.reg_dst;
    assign reg_write_o     = ctrl.reg_write;
    assign alu_src_a_o     = ctrl.alu_src_a;
    assign alu_src_b_o     = ctrl.alu_src_b;
    assign alu_op_o        = ctrl.alu_op;
    assign pc_source_o     = ctrl.pc_source;
    assign instr_done_o    = ctrl.instr_done;
    assign illegal_op_o    = ctrl.illegal_op;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multi-cycle control FSM: per-cycle control words
// compared against hand-written constants for each instruction class.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .opcode_i        (opcode),
        .zero_i          (zero),
        .mem_ready_i     (mem_ready),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .i_or_d_o        (i_or_d),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .ir_write_o      (ir_write),
        .mem_to_reg_o    (mem_to_reg),
        .reg_dst_o       (reg_dst),
        .reg_write_o     (reg_write),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .alu_op_o        (alu_op),
        .pc_source_o     (pc_source),
        .instr_done_o    (instr_done),
        .illegal_op_o    (illegal_op)
    );

    // Field order: pw pwc iord mrd mwr irw m2r rdst rwr asa asb[2] aop[2] psrc[2] done ill
    logic [17:0] outs;
    logic [7:0]  strobes;
    assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, instr_done, illegal_op};
    assign strobes = {pc_write, pc_write_cond, ir_write, reg_write, mem_write,
                      mem_read, instr_done, illegal_op};

    localparam logic [17:0] E_FETCH   = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] E_FWAIT   = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] E_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] E_DEC_ILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
    localparam logic [17:0] E_MEMADR  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] E_MEMRD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] E_MEMWB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
    localparam logic [17:0] E_MEMWR   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
    localparam logic [17:0] E_MWWAIT  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] E_EXEC    = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] E_RWB     = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
    localparam logic [17:0] E_BRANCH  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [17:0] E_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
    localparam logic [17:0] E_ADDIEX  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] E_ADDIWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, compare at the falling edge, advance past the rising edge.
    task automatic step(input string tag, input logic [5:0] op, input logic mr,
                        input logic [17:0] exp);
        opcode    = op;
        mem_ready = mr;
        @(negedge clk);
        chk(tag, {14'd0, outs}, {14'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic rst_step(input string tag, input logic [5:0] op, input logic mr);
        rst       = 1'b1;
        opcode    = op;
        mem_ready = mr;
        @(negedge clk);
        chk(tag, {24'd0, strobes}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_step("rst0", 6'd0, 1'b1);
        rst_step("rst1", 6'd0, 1'b1);
        rst = 1'b0;

        // R-type; opcode change in EXEC must be ignored
        step("r_fetch",  6'b000000, 1'b1, E_FETCH);
        step("r_decode", 6'b000000, 1'b1, E_DECODE);
        step("r_exec",   6'b000010, 1'b1, E_EXEC);
        step("r_rwb",    6'b000010, 1'b1, E_RWB);

        // lw with 3 stall cycles in MEMRD -> 8 cycles
        step("lw_fetch",  6'b100011, 1'b1, E_FETCH);
        step("lw_decode", 6'b100011, 1'b1, E_DECODE);
        step("lw_memadr", 6'b100011, 1'b1, E_MEMADR);
        for (int i = 0; i < 3; i++)
            step("lw_memrd_wait", 6'b100011, 1'b0, E_MEMRD);
        step("lw_memrd", 6'b100011, 1'b1, E_MEMRD);
        step("lw_memwb", 6'b100011, 1'b1, E_MEMWB);

        // sw, no stall
        step("sw_fetch",  6'b101011, 1'b1, E_FETCH);
        step("sw_decode", 6'b101011, 1'b1, E_DECODE);
        step("sw_memadr", 6'b101011, 1'b1, E_MEMADR);
        step("sw_memwr",  6'b101011, 1'b1, E_MEMWR);

        // beq and j
        zero = 1'b1;
        step("beq_fetch",  6'b000100, 1'b1, E_FETCH);
        step("beq_decode", 6'b000100, 1'b1, E_DECODE);
        step("beq_branch", 6'b000100, 1'b1, E_BRANCH);
        zero = 1'b0;
        step("j_fetch",  6'b000010, 1'b1, E_FETCH);
        step("j_decode", 6'b000010, 1'b1, E_DECODE);
        step("j_jump",   6'b000010, 1'b1, E_JUMP);

        // addi
        step("addi_fetch",  6'b001000, 1'b1, E_FETCH);
        step("addi_decode", 6'b001000, 1'b1, E_DECODE);
        step("addi_ex",     6'b001000, 1'b1, E_ADDIEX);
        step("addi_wb",     6'b001000, 1'b1, E_ADDIWB);

        // illegal opcode returns to FETCH after DECODE
        step("ill_fetch",  6'b111111, 1'b1, E_FETCH);
        step("ill_decode", 6'b111111, 1'b1, E_DEC_ILL);

        // FETCH stall, then sw with a MEMWR stall
        step("fw_wait0",   6'b101011, 1'b0, E_FWAIT);
        step("fw_wait1",   6'b101011, 1'b0, E_FWAIT);
        step("fw_fetch",   6'b101011, 1'b1, E_FETCH);
        step("sws_decode", 6'b101011, 1'b1, E_DECODE);
        step("sws_memadr", 6'b101011, 1'b1, E_MEMADR);
        step("sws_wait",   6'b101011, 1'b0, E_MWWAIT);
        step("sws_memwr",  6'b101011, 1'b1, E_MEMWR);

        // Reset for 2 cycles mid-EXEC; second reset cycle sits in FETCH with mem_ready=1
        step("rr_fetch",  6'b000000, 1'b1, E_FETCH);
        step("rr_decode", 6'b000000, 1'b1, E_DECODE);
        rst_step("rr_rst_exec",  6'b000000, 1'b1);
        rst_step("rr_rst_fetch", 6'b000000, 1'b1);
        rst = 1'b0;
        step("rr_post_fetch",  6'b000010, 1'b1, E_FETCH);
        step("rr_post_decode", 6'b000010, 1'b1, E_DECODE);
        step("rr_post_jump",   6'b000010, 1'b1, E_JUMP);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
